div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Ports SHALL be as listed; one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  DIV/DIVU request from EX.
REQ-005 req_signed  in  1  1 = DIV, 0 = DIVU.
REQ-006 req_x, req_y  in  32 each  dividend, divisor.
REQ-007 req_ready  out  1  request accepted on req_valid&req_ready.
REQ-008 flush  in  1  pipeline flush; aborts any pending division.
REQ-009 mt_we, mt_sel, mt_wdata  in  1/1/32  MTHI (sel=1) / MTLO (sel=0) write.
REQ-010 div_op, div_signed  out  1/1  start pulse and signedness to divider.
REQ-011 div_x, div_y  out  32 each  operands to divider.
REQ-012 div_cancel  out  1  abort to divider.
REQ-013 div_s, div_r, div_complete  in  32/32/1  quotient, remainder, done from divider.
REQ-014 hi, lo  out  32 each  architectural HI (remainder) / LO (quotient).
REQ-015 busy  out  1  division in flight; pipeline stalls MFHI/MFLO/MT*/DIV on it.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT; req_ready = (state==IDLE); busy = (state!=IDLE).
REQ-017 IDLE: req_valid&~flush SHALL latch req_x/req_y/req_signed into operand registers and go to START.
REQ-018 START: div_op SHALL be 1 for exactly this one cycle (0 if flush), then go to WAIT.
REQ-019 div_x/div_y/div_signed SHALL be driven from the operand registers, stable from START until return to IDLE.
REQ-020 WAIT: on div_complete, lo<=div_s, hi<=div_r at that clock edge; state -> IDLE.
REQ-021 Latency: with divider completing 9 cycles after div_op, hi/lo and busy=0 SHALL be visible on the 10th cycle after the div_op cycle.
REQ-022 flush in START or WAIT SHALL assert div_cancel that cycle, go to IDLE, leave hi/lo unchanged; flush has priority over same-cycle div_complete.
REQ-023 flush in IDLE SHALL block acceptance of a same-cycle request; div_cancel SHALL be 0 in IDLE.
REQ-024 div_complete outside WAIT SHALL be ignored.
REQ-025 mt_we SHALL write hi (mt_sel=1) or lo (mt_sel=0) only in IDLE; ignored while busy.
REQ-026 div_op, div_cancel SHALL never be 1 simultaneously except START with flush (div_op then 0).
REQ-027 Divide-by-zero (without macro) SHALL be forwarded unchanged; hi/lo take whatever the divider returns.

Reset
REQ-028 Reset SHALL force state=IDLE, hi=lo=0, operand registers=0, div_op=div_cancel=0, busy=0, req_ready=1, asynchronously.
REQ-029 Reset mid-division SHALL discard the operation without asserting div_cancel; the divider is reset by its own reset.

Configuration
REQ-030 Macro DIV_CTRL_ZERO_BYPASS_EN defined: accepted request with req_y==0 SHALL skip START/WAIT, raise no div_op, and in the cycle after acceptance write lo=32'hFFFFFFFF, hi=req_x; busy high for that one cycle only.
REQ-031 Macro undefined: req_y==0 SHALL follow the normal START/WAIT path (REQ-027).

Verification
REQ-032 DIVU x=100, y=7, divider model 9-cycle -> one div_op pulse, div_signed=0; lo=14, hi=2 on 10th cycle after div_op; busy then 0.
REQ-033 DIV x=-100 (32'hFFFFFF9C), y=7 -> div_signed=1; lo=32'hFFFFFFF2 (-14), hi=32'hFFFFFFFE (-2).
REQ-034 DIVU 50/5, flush 4 cycles after div_op -> div_cancel one cycle, state IDLE, hi/lo keep prior values (MTHI 0xAA, MTLO 0xBB beforehand).
REQ-035 mt_we=1, mt_sel=1, wdata=0x1234 while busy -> hi unchanged; after completion MTLO 0x55 in IDLE -> lo=0x55 next cycle.
REQ-036 DIVU x=9, y=0: macro defined -> no div_op, lo=32'hFFFFFFFF, hi=9 the cycle after acceptance; undefined -> div_op issued, divider result written.
REQ-037 Reset asserted in WAIT -> hi=lo=0, busy=0, req_ready=1 immediately; subsequent stray div_complete ignored.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Request, divider-side and architectural HI/LO signals of the DIV/DIVU controller.
// The controller connects through the slave modport; the pipeline/divider side uses master.
interface div_ctrl_if;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_signed;
  logic [DATA_W-1:0] req_x;
  logic [DATA_W-1:0] req_y;
  logic              req_ready;
  logic              flush;
  logic              mt_we;
  logic              mt_sel;
  logic [DATA_W-1:0] mt_wdata;
  logic              div_op;
  logic              div_signed;
  logic [DATA_W-1:0] div_x;
  logic [DATA_W-1:0] div_y;
  logic              div_cancel;
  logic [DATA_W-1:0] div_s;
  logic [DATA_W-1:0] div_r;
  logic              div_complete;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;

  modport slave (
    input  req_valid, req_signed, req_x, req_y, flush,
    input  mt_we, mt_sel, mt_wdata,
    input  div_s, div_r, div_complete,
    output req_ready, div_op, div_signed, div_x, div_y, div_cancel,
    output hi, lo, busy
  );

  modport master (
    output req_valid, req_signed, req_x, req_y, flush,
    output mt_we, mt_sel, mt_wdata,
    output div_s, div_r, div_complete,
    input  req_ready, div_op, div_signed, div_x, div_y, div_cancel,
    input  hi, lo, busy
  );
endinterface

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencing between EX and a multi-cycle divider, owning the HI/LO registers.
// Optional macro DIV_CTRL_ZERO_BYPASS_EN resolves divide-by-zero locally without the divider.
module div_ctrl (
  input  logic      clk,
  input  logic      reset,
  div_ctrl_if.slave bus
);
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ZERO  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              div_op_c;
  logic              div_cancel_c;

  // div_op/div_cancel must react to flush in the same cycle, so they are decoded combinationally
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sgn_d        = sgn_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_op_c     = 1'b0;
    div_cancel_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.mt_we) begin
          if (bus.mt_sel) hi_d = bus.mt_wdata;
          else            lo_d = bus.mt_wdata;
        end
        if (bus.req_valid && !bus.flush) begin
          x_d     = bus.req_x;
          y_d     = bus.req_y;
          sgn_d   = bus.req_signed;
          state_d = S_START;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
          if (bus.req_y == '0) begin
            lo_d    = '1;
            hi_d    = bus.req_x;
            state_d = S_ZERO;
          end
`endif
        end
      end
      S_START: begin
        if (bus.flush) begin
          div_cancel_c = 1'b1;
          state_d      = S_IDLE;
        end else begin
          div_op_c = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Flush wins over a completion arriving in the same cycle
        if (bus.flush) begin
          div_cancel_c = 1'b1;
          state_d      = S_IDLE;
        end else if (bus.div_complete) begin
          lo_d    = bus.div_s;
          hi_d    = bus.div_r;
          state_d = S_IDLE;
        end
      end
      S_ZERO:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.div_op     = div_op_c;
  assign bus.div_cancel = div_cancel_c;
  assign bus.div_x      = x_q;
  assign bus.div_y      = y_q;
  assign bus.div_signed = sgn_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: 9-cycle divider model, transaction-level HI/LO model
// compared every cycle, plus directed cases with hand-computed results.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic reset;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Divider results by plain arithmetic; divide-by-zero returns all-ones / dividend
  function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (y == 32'd0) return 32'hFFFF_FFFF;
    if (s) return 32'($signed(x) / $signed(y));
    return x / y;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (y == 32'd0) return x;
    if (s) return 32'($signed(x) % $signed(y));
    return x % y;
  endfunction

  // Divider model: complete pulses 9 cycles after the div_op cycle
  logic        dv_done = 1'b0;
  logic [31:0] dv_q = '0, dv_r = '0;
  logic        stray = 1'b0;
  logic [31:0] st_s = '0, st_r = '0;
  assign bus.div_complete = dv_done | stray;
  assign bus.div_s = dv_done ? dv_q : st_s;
  assign bus.div_r = dv_done ? dv_r : st_r;

  initial begin
    int          cnt;
    logic        op_s, cancel_s, rst_s;
    logic [31:0] cx, cy;
    logic        cs;
    cnt = 0;
    forever begin
      @(negedge clk);
      op_s = bus.div_op; cancel_s = bus.div_cancel; rst_s = reset;
      cx = bus.div_x; cy = bus.div_y; cs = bus.div_signed;
      @(posedge clk); #1;
      dv_done = 1'b0;
      if (rst_s || reset || cancel_s) cnt = 0;
      else if (op_s) begin
        cnt  = 8;
        dv_q = ref_q(cx, cy, cs);
        dv_r = ref_r(cx, cy, cs);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) dv_done = 1'b1;
      end
    end
  end

  // Transaction-level model of the architectural outputs, compared every cycle
  bit          m_busy, m_zero;
  int          m_age;
  logic [31:0] m_hi, m_lo, m_x, m_y;
  logic        m_s;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_op", 32'(bus.div_op), 32'd0);
      chk("rst_cancel", 32'(bus.div_cancel), 32'd0);
      m_busy = 1'b0; m_zero = 1'b0; m_age = 0;
      m_hi = '0; m_lo = '0; m_x = '0; m_y = '0; m_s = 1'b0;
    end else begin
      chk("m_busy", 32'(bus.busy), 32'(m_busy));
      chk("m_ready", 32'(bus.req_ready), 32'(!m_busy));
      chk("m_op", 32'(bus.div_op), 32'(m_busy && !m_zero && m_age == 1 && !bus.flush));
      chk("m_cancel", 32'(bus.div_cancel), 32'(m_busy && !m_zero && bus.flush));
      chk("m_hi", bus.hi, m_hi);
      chk("m_lo", bus.lo, m_lo);
      if (m_busy && !m_zero) begin
        chk("m_div_x", bus.div_x, m_x);
        chk("m_div_y", bus.div_y, m_y);
        chk("m_div_signed", 32'(bus.div_signed), 32'(m_s));
      end
      if (!m_busy) begin
        if (bus.mt_we) begin
          if (bus.mt_sel) m_hi = bus.mt_wdata;
          else            m_lo = bus.mt_wdata;
        end
        if (bus.req_valid && !bus.flush) begin
          m_x = bus.req_x; m_y = bus.req_y; m_s = bus.req_signed;
          m_busy = 1'b1; m_age = 1; m_zero = 1'b0;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
          if (bus.req_y == 32'd0) begin
            m_zero = 1'b1; m_lo = 32'hFFFF_FFFF; m_hi = bus.req_x;
          end
`endif
        end
      end else if (m_zero || bus.flush) begin
        m_busy = 1'b0;
      end else begin
        if (m_age >= 2 && bus.div_complete) begin
          m_lo = ref_q(m_x, m_y, m_s);
          m_hi = ref_r(m_x, m_y, m_s);
          m_busy = 1'b0;
        end
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents a request for one cycle; returns in the cycle after acceptance
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    tick();
    bus.req_valid = 1'b1; bus.req_x = x; bus.req_y = y; bus.req_signed = s;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] d);
    tick();
    bus.mt_we = 1'b1; bus.mt_sel = sel; bus.mt_wdata = d;
    tick();
    bus.mt_we = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
      else tick();
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_signed = 1'b0; bus.req_x = '0; bus.req_y = '0;
    bus.flush = 1'b0; bus.mt_we = 1'b0; bus.mt_sel = 1'b0; bus.mt_wdata = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // DIVU 100/7: result lands on the 10th cycle after div_op
    issue(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    chk("divu_op", 32'(bus.div_op), 32'd1);
    chk("divu_signed", 32'(bus.div_signed), 32'd0);
    repeat (9) tick();
    @(negedge clk);
    chk("divu_busy_c9", 32'(bus.busy), 32'd1);
    tick();
    @(negedge clk);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);
    chk("divu_busy_c10", 32'(bus.busy), 32'd0);

    // DIV -100/7
    issue(32'hFFFF_FF9C, 32'd7, 1'b1);
    @(negedge clk);
    chk("div_signed", 32'(bus.div_signed), 32'd1);
    wait_idle("div_neg_done");
    chk("div_neg_lo", bus.lo, 32'hFFFF_FFF2);
    chk("div_neg_hi", bus.hi, 32'hFFFF_FFFE);

    // DIV 100/-7
    issue(32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_idle("div_negy_done");
    chk("div_negy_lo", bus.lo, 32'hFFFF_FFF2);
    chk("div_negy_hi", bus.hi, 32'd2);

    // Flush in WAIT keeps MTHI/MTLO values
    mt_write(1'b1, 32'hAA);
    mt_write(1'b0, 32'hBB);
    @(negedge clk);
    chk("mt_hi", bus.hi, 32'hAA);
    chk("mt_lo", bus.lo, 32'hBB);
    issue(32'd50, 32'd5, 1'b0);
    repeat (4) tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_cancel", 32'(bus.div_cancel), 32'd1);
    chk("flush_wait_op", 32'(bus.div_op), 32'd0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_wait_idle", 32'(bus.req_ready), 32'd1);
    chk("flush_wait_cancel_off", 32'(bus.div_cancel), 32'd0);
    chk("flush_wait_hi", bus.hi, 32'hAA);
    chk("flush_wait_lo", bus.lo, 32'hBB);
    repeat (12) tick();
    @(negedge clk);
    chk("flush_no_late_lo", bus.lo, 32'hBB);

    // Flush in START suppresses div_op
    issue(32'd50, 32'd5, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_start_op", 32'(bus.div_op), 32'd0);
    chk("flush_start_cancel", 32'(bus.div_cancel), 32'd1);
    tick();
    bus.flush = 1'b0;

    // Flush in IDLE blocks a same-cycle request
    tick();
    bus.req_valid = 1'b1; bus.req_x = 32'd8; bus.req_y = 32'd2; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_cancel", 32'(bus.div_cancel), 32'd0);
    tick();
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 32'(bus.busy), 32'd0);

    // MTHI while busy is ignored; MTLO in IDLE lands next cycle
    issue(32'd20, 32'd3, 1'b0);
    repeat (3) tick();
    bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_wdata = 32'h1234;
    tick();
    bus.mt_we = 1'b0;
    wait_idle("mt_busy_done");
    chk("mt_busy_hi", bus.hi, 32'd2);
    chk("mt_busy_lo", bus.lo, 32'd6);
    mt_write(1'b0, 32'h55);
    @(negedge clk);
    chk("mtlo_idle", bus.lo, 32'h55);

    // DIVU 9/0
    issue(32'd9, 32'd0, 1'b0);
    @(negedge clk);
`ifdef DIV_CTRL_ZERO_BYPASS_EN
    chk("dz_op", 32'(bus.div_op), 32'd0);
    chk("dz_busy", 32'(bus.busy), 32'd1);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dz_hi", bus.hi, 32'd9);
    tick();
    @(negedge clk);
    chk("dz_busy_off", 32'(bus.busy), 32'd0);
`else
    chk("dz_op", 32'(bus.div_op), 32'd1);
    wait_idle("dz_done");
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dz_hi", bus.hi, 32'd9);
`endif

    // Reset during WAIT, then a stray completion
    issue(32'd100, 32'd7, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_hi", bus.hi, 32'd0);
    chk("rstw_lo", bus.lo, 32'd0);
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_cancel", 32'(bus.div_cancel), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    stray = 1'b1; st_s = 32'h77; st_r = 32'h66;
    tick();
    stray = 1'b0;
    @(negedge clk);
    chk("stray_hi", bus.hi, 32'd0);
    chk("stray_lo", bus.lo, 32'd0);
    chk("stray_busy", 32'(bus.busy), 32'd0);

    repeat (15) tick();
    @(negedge clk);
    chk("final_idle", 32'(bus.req_ready), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
